// File: rtl/sirv_icb2to1_arbt_bus_pkg.sv
// ---------------------------------------------------------------------------
// sirv_icb2to1_arbt_bus_pkg
//   Shared definitions for the 2-to-1 ICB arbiter bus.
//   - ARBT_FIXED / ARBT_RR : values of the ARBT_SCHEME parameter
//   - srcId_t              : initiator identifier (0 = i0, 1 = i1)
//   - icbCmdPayloadW()     : width of a packed ICB command payload
//                            {addr, read, burst, beat, wdata, wmask, lock, excl, size}
// ---------------------------------------------------------------------------
package sirv_icb2to1_arbt_bus_pkg;

    localparam int ARBT_FIXED = 0;
    localparam int ARBT_RR    = 1;

    typedef logic srcId_t;

    function automatic int icbCmdPayloadW(input int aw, input int dw);
        return aw + 1 + 2 + 2 + dw + dw / 8 + 1 + 1 + 2;
    endfunction

endpackage

// File: rtl/sirv_gnrl_fifo.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_fifo
//   General-purpose synchronous FIFO with valid/ready handshakes on both sides.
//   Parameters:
//     CUT_READY : 1 = pushRdy_o depends only on fullness; 0 = a pop in the
//                 same cycle also frees a slot for the push
//     MSKO      : 1 = popDat_o forced to zero while empty
//     DP        : depth (>= 1)
//     DW        : data width
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     pushVld_i/pushRdy_o   : write handshake, pushDat_i write data
//     popVld_o/popRdy_i     : read handshake, popDat_o head data
//     full_o                : all DP entries occupied
// ---------------------------------------------------------------------------
module sirv_gnrl_fifo
    import sirv_icb2to1_arbt_bus_pkg::*;
#(
    parameter int CUT_READY = 0,
    parameter int MSKO      = 0,
    parameter int DP        = 8,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pushVld_i,
    output logic          pushRdy_o,
    input  logic [DW-1:0] pushDat_i,
    output logic          popVld_o,
    input  logic          popRdy_i,
    output logic [DW-1:0] popDat_o,
    output logic          full_o
);

    localparam int PTRW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CNTW = $clog2(DP + 1);
    localparam int MEMD = 1 << PTRW;

    logic [DW-1:0]   mem_q [MEMD];
    logic [PTRW-1:0] wrPtr_q, wrPtr_d;
    logic [PTRW-1:0] rdPtr_q, rdPtr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push, pop, empty;

    function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
        return (p == PTRW'(DP - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (cnt_q == '0);
    assign full_o    = (cnt_q == CNTW'(DP));
    assign pushRdy_o = (CUT_READY != 0) ? ~full_o : (~full_o | popRdy_i);
    assign popVld_o  = ~empty;
    assign popDat_o  = ((MSKO != 0) && empty) ? '0 : mem_q[rdPtr_q];
    assign push      = pushVld_i & pushRdy_o;
    assign pop       = popVld_o & popRdy_i;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
    // the count unchanged while both pointers advance.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        cnt_d   = cnt_q;
        if (push) wrPtr_d = nextPtr(wrPtr_q);
        if (pop)  rdPtr_d = nextPtr(rdPtr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state is reset; storage contents are don't-care until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= pushDat_i;
    end

endmodule

// File: rtl/sirv_icb2to1_arbt_bus.sv
// ---------------------------------------------------------------------------
// sirv_icb2to1_arbt_bus
//   Merges two ICB initiators (i0, i1) onto one ICB target (o).
//   Commands are arbitrated (fixed priority or round-robin), a stalled grant
//   is held until it handshakes, a lock sequence keeps the bus to its owner,
//   and the source of every accepted command is queued so that in-order
//   responses return to the right initiator.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     iN_icb_cmd_*            : initiator command channels (N = 0, 1)
//     iN_icb_rsp_*            : initiator response channels (N = 0, 1)
//     o_icb_cmd_*             : merged command channel to the target
//     o_icb_rsp_*             : response channel from the target
// ---------------------------------------------------------------------------
module sirv_icb2to1_arbt_bus
    import sirv_icb2to1_arbt_bus_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int ARBT_SCHEME     = 0,
    parameter int OUTS_NUM        = 1,
    parameter int ALLOW_0CYCL_RSP = 1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i0_icb_cmd_valid,
    output logic            i0_icb_cmd_ready,
    input  logic [AW-1:0]   i0_icb_cmd_addr,
    input  logic            i0_icb_cmd_read,
    input  logic [1:0]      i0_icb_cmd_burst,
    input  logic [1:0]      i0_icb_cmd_beat,
    input  logic [DW-1:0]   i0_icb_cmd_wdata,
    input  logic [DW/8-1:0] i0_icb_cmd_wmask,
    input  logic            i0_icb_cmd_lock,
    input  logic            i0_icb_cmd_excl,
    input  logic [1:0]      i0_icb_cmd_size,
    output logic            i0_icb_rsp_valid,
    input  logic            i0_icb_rsp_ready,
    output logic            i0_icb_rsp_err,
    output logic            i0_icb_rsp_excl_ok,
    output logic [DW-1:0]   i0_icb_rsp_rdata,

    input  logic            i1_icb_cmd_valid,
    output logic            i1_icb_cmd_ready,
    input  logic [AW-1:0]   i1_icb_cmd_addr,
    input  logic            i1_icb_cmd_read,
    input  logic [1:0]      i1_icb_cmd_burst,
    input  logic [1:0]      i1_icb_cmd_beat,
    input  logic [DW-1:0]   i1_icb_cmd_wdata,
    input  logic [DW/8-1:0] i1_icb_cmd_wmask,
    input  logic            i1_icb_cmd_lock,
    input  logic            i1_icb_cmd_excl,
    input  logic [1:0]      i1_icb_cmd_size,
    output logic            i1_icb_rsp_valid,
    input  logic            i1_icb_rsp_ready,
    output logic            i1_icb_rsp_err,
    output logic            i1_icb_rsp_excl_ok,
    output logic [DW-1:0]   i1_icb_rsp_rdata,

    output logic            o_icb_cmd_valid,
    input  logic            o_icb_cmd_ready,
    output logic [AW-1:0]   o_icb_cmd_addr,
    output logic            o_icb_cmd_read,
    output logic [1:0]      o_icb_cmd_burst,
    output logic [1:0]      o_icb_cmd_beat,
    output logic [DW-1:0]   o_icb_cmd_wdata,
    output logic [DW/8-1:0] o_icb_cmd_wmask,
    output logic            o_icb_cmd_lock,
    output logic            o_icb_cmd_excl,
    output logic [1:0]      o_icb_cmd_size,
    input  logic            o_icb_rsp_valid,
    output logic            o_icb_rsp_ready,
    input  logic            o_icb_rsp_err,
    input  logic            o_icb_rsp_excl_ok,
    input  logic [DW-1:0]   o_icb_rsp_rdata
);

    localparam int CMD_PW = icbCmdPayloadW(AW, DW);

    logic [CMD_PW-1:0] i0Payload, i1Payload, oPayload;
    logic [1:0]        eligible, req;
    srcId_t            grant, rspSel;
    logic              cmdHsk, rspHsk, bypass, routeOk;

    srcId_t rrPtr_q, rrPtr_d;
    logic   holdVld_q, holdVld_d;
    srcId_t holdId_q, holdId_d;
    logic   lockVld_q, lockVld_d;
    srcId_t lockId_q, lockId_d;

    logic   fifoPushVld, fifoPushRdy, fifoPopVld, fifoPopRdy, fifoFull;
    logic [0:0] fifoHead;

    assign i0Payload = {i0_icb_cmd_addr, i0_icb_cmd_read, i0_icb_cmd_burst, i0_icb_cmd_beat,
                        i0_icb_cmd_wdata, i0_icb_cmd_wmask, i0_icb_cmd_lock, i0_icb_cmd_excl,
                        i0_icb_cmd_size};
    assign i1Payload = {i1_icb_cmd_addr, i1_icb_cmd_read, i1_icb_cmd_burst, i1_icb_cmd_beat,
                        i1_icb_cmd_wdata, i1_icb_cmd_wmask, i1_icb_cmd_lock, i1_icb_cmd_excl,
                        i1_icb_cmd_size};

    // Arbitration: a full source queue blocks everyone, an active lock admits
    // only its owner, and a held grant overrides the arbiter so the target
    // never sees the payload change while stalled. Arbitration runs over the
    // eligible requesters so a locked-out port cannot steal the grant.
    always_comb begin
        eligible = 2'b11;
        if (lockVld_q) eligible = lockId_q ? 2'b10 : 2'b01;
        if (fifoFull)  eligible = 2'b00;
        req = {i1_icb_cmd_valid, i0_icb_cmd_valid} & eligible;
        if (holdVld_q) begin
            grant = holdId_q;
        end else if (req == 2'b11) begin
            grant = (ARBT_SCHEME == ARBT_FIXED) ? 1'b0 : ~rrPtr_q;
        end else begin
            grant = req[1];
        end
    end

    assign o_icb_cmd_valid  = req[grant];
    assign i0_icb_cmd_ready = (grant == 1'b0) & o_icb_cmd_ready & eligible[0];
    assign i1_icb_cmd_ready = (grant == 1'b1) & o_icb_cmd_ready & eligible[1];
    assign oPayload         = grant ? i1Payload : i0Payload;
    assign {o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_burst, o_icb_cmd_beat,
            o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_lock, o_icb_cmd_excl,
            o_icb_cmd_size} = oPayload;
    assign cmdHsk = o_icb_cmd_valid & o_icb_cmd_ready;

    // Response routing: the queue head names the destination. With an empty
    // queue, a response may ride along with the command handshaking this
    // cycle; otherwise the target is back-pressured rather than dropped.
    assign bypass  = (ALLOW_0CYCL_RSP != 0) & ~fifoPopVld & cmdHsk;
    assign routeOk = fifoPopVld | bypass;
    assign rspSel  = bypass ? grant : fifoHead[0];

    assign o_icb_rsp_ready    = routeOk & (rspSel ? i1_icb_rsp_ready : i0_icb_rsp_ready);
    assign i0_icb_rsp_valid   = o_icb_rsp_valid & routeOk & ~rspSel;
    assign i1_icb_rsp_valid   = o_icb_rsp_valid & routeOk & rspSel;
    assign i0_icb_rsp_err     = o_icb_rsp_err;
    assign i1_icb_rsp_err     = o_icb_rsp_err;
    assign i0_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
    assign i1_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
    assign i0_icb_rsp_rdata   = o_icb_rsp_rdata;
    assign i1_icb_rsp_rdata   = o_icb_rsp_rdata;
    assign rspHsk = o_icb_rsp_valid & o_icb_rsp_ready;

    // A command whose response completed through the bypass never enters
    // the queue, and that response must not pop anything either.
    assign fifoPushVld = cmdHsk & ~(bypass & rspHsk);
    assign fifoPopRdy  = rspHsk & ~bypass;

    sirv_gnrl_fifo #(
        .CUT_READY (0),
        .MSKO      (0),
        .DP        (OUTS_NUM),
        .DW        (1)
    ) uSrcFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .pushVld_i (fifoPushVld),
        .pushRdy_o (fifoPushRdy),
        .pushDat_i (grant),
        .popVld_o  (fifoPopVld),
        .popRdy_i  (fifoPopRdy),
        .popDat_o  (fifoHead),
        .full_o    (fifoFull)
    );

    // Eligibility already excludes pushes into a full queue.
    always_ff @(posedge clk) begin
        if (rst_n && fifoPushVld) assert (fifoPushRdy);
    end

    // Next state for round-robin pointer, grant hold and lock ownership.
    // A handshake releases the hold, records the winner for round-robin and
    // opens or closes a lock sequence; a stall pins the current grant.
    always_comb begin
        rrPtr_d   = rrPtr_q;
        holdVld_d = holdVld_q;
        holdId_d  = holdId_q;
        lockVld_d = lockVld_q;
        lockId_d  = lockId_q;
        if (cmdHsk) begin
            rrPtr_d   = grant;
            holdVld_d = 1'b0;
            if (o_icb_cmd_lock) begin
                lockVld_d = 1'b1;
                lockId_d  = grant;
            end else if (lockVld_q && (lockId_q == grant)) begin
                lockVld_d = 1'b0;
            end
        end else if (o_icb_cmd_valid) begin
            holdVld_d = 1'b1;
            holdId_d  = grant;
        end
    end

    // Arbiter state registers; rrPtr resets to 1 so i0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q   <= 1'b1;
            holdVld_q <= 1'b0;
            holdId_q  <= 1'b0;
            lockVld_q <= 1'b0;
            lockId_q  <= 1'b0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            holdVld_q <= holdVld_d;
            holdId_q  <= holdId_d;
            lockVld_q <= lockVld_d;
            lockId_q  <= lockId_d;
        end
    end

endmodule
